// File: rtl/raycast_frame_buffer.sv
// Double-buffered 320x180 frame store: upstream writes the back array while the
// display reads the front array upscaled 4x; arrays swap on the first blanking line.
module raycast_frame_buffer #(
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int PIXEL_WIDTH        = 8
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   active_draw_in,
  output logic [1:0]             fb_ready_to_switch_out,
  output logic                   frame_swap_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out
);

  localparam int Depth  = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int HScale = $clog2(FULL_SCREEN_WIDTH / SCREEN_WIDTH);
  localparam int VScale = $clog2(FULL_SCREEN_HEIGHT / SCREEN_HEIGHT);

  typedef enum logic {WRITING, PENDING_SWAP} state_t;

  state_t                 state_q, state_d;
  logic                   frontSel_q, frontSel_d;
  logic [1:0]             status_q, status_d;
  logic                   swap_q, swap_d;
  logic [PIXEL_WIDTH-1:0] rd0_q, rd1_q;
  logic                   active1_q, sel1_q;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;

  logic [PIXEL_WIDTH-1:0] mem0 [Depth];
  logic [PIXEL_WIDTH-1:0] mem1 [Depth];

  logic        swapCond, addrOk, wrEn, wrEn0, wrEn1;
  logic [7:0]  vCell;
  logic [15:0] hCell, rdAddr;

  assign swapCond = (hcount_in == 11'd0) && (vcount_in == 10'(FULL_SCREEN_HEIGHT));
  assign addrOk   = ray_address_in < 16'(Depth);
  assign wrEn     = (state_q == WRITING) && ray_valid_in && addrOk;
  assign wrEn0    = wrEn && frontSel_q;
  assign wrEn1    = wrEn && !frontSel_q;

  // Row stride of 320 built as 256 + 64 so no multiplier is needed.
  assign hCell  = 16'(hcount_in >> HScale);
  assign vCell  = 8'(vcount_in >> VScale);
  assign rdAddr = hCell + {vCell, 8'b0} + {2'b0, vCell, 6'b0};

  always_comb begin
    state_d    = state_q;
    frontSel_d = frontSel_q;
    swap_d     = 1'b0;
    case (state_q)
      WRITING: begin
        if (ray_valid_in && ray_last_pixel_in) state_d = PENDING_SWAP;
      end
      PENDING_SWAP: begin
        if (swapCond) begin
          state_d    = WRITING;
          frontSel_d = !frontSel_q;
          swap_d     = 1'b1;
        end
      end
      default: state_d = WRITING;
    endcase
    status_d = (state_d == WRITING) ? 2'b11 : 2'b01;
    pixel_d  = '0;
    if (active1_q) pixel_d = sel1_q ? rd1_q : rd0_q;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= WRITING;
      frontSel_q <= 1'b0;
      status_q   <= 2'b11;
      swap_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      active1_q  <= 1'b0;
      sel1_q     <= 1'b0;
      pixel_q    <= '0;
    end else begin
      state_q    <= state_d;
      frontSel_q <= frontSel_d;
      status_q   <= status_d;
      swap_q     <= swap_d;
      rd0_q      <= mem0[rdAddr];
      rd1_q      <= mem1[rdAddr];
      active1_q  <= active_draw_in;
      sel1_q     <= frontSel_q;
      pixel_q    <= pixel_d;
    end
  end

  // Arrays hold their contents across reset; only the back array is ever written.
  always_ff @(posedge pixel_clk_in) begin
    if (wrEn0) mem0[ray_address_in] <= ray_pixel_in;
    if (wrEn1) mem1[ray_address_in] <= ray_pixel_in;
  end

  assign fb_ready_to_switch_out = status_q;
  assign frame_swap_out         = swap_q;
  assign pixel_out              = pixel_q;

endmodule

// File: doc/raycast_frame_buffer.md
# raycast_frame_buffer

Double-buffered 320x180x8 frame store between the flattening/transformation stage and the 1280x720 video output. Pixel writes (address, colour, last-pixel flag) land in the back buffer. The video side reads the front buffer, upscaled 4x in each axis. The two buffers swap only at a display frame boundary after a complete frame has been written. The 2-bit `fb_ready_to_switch_out` status gates the upstream stage: upstream starts a new frame only when the status reads 3.

## Interface
Parameters:
- `SCREEN_WIDTH`, 320: logical frame width in pixels.
- `SCREEN_HEIGHT`, 180: logical frame height in pixels.
- `FULL_SCREEN_WIDTH`, 1280: active display width.
- `FULL_SCREEN_HEIGHT`, 720: active display height.
- `PIXEL_WIDTH`, 8: stored colour width.

Ports:
- `pixel_clk_in`  in  1  the only clock; every register is on its rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `ray_valid_in`  in  1  qualifies the write fields on this cycle.
- `ray_address_in`  in  16  linear write address, h + v*SCREEN_WIDTH.
- `ray_pixel_in`  in  8  colour to write.
- `ray_last_pixel_in`  in  1  marks the final write of a frame; only meaningful with `ray_valid_in`.
- `hcount_in`  in  11  display column from the video timing generator.
- `vcount_in`  in  10  display row from the video timing generator.
- `active_draw_in`  in  1  high inside the 1280x720 active region.
- `fb_ready_to_switch_out`  out  2  back-buffer status; 3 means "write a new frame".
- `frame_swap_out`  out  1  one-cycle pulse on the cycle the buffers swap.
- `pixel_out`  out  8  display colour, registered.

## Operation
- Storage is two arrays of SCREEN_WIDTH*SCREEN_HEIGHT = 57600 words of 8 bits, each with one write port and one read port.
- Register `front_sel`:
  - The display reads array `front_sel`.
  - Writes go to array `!front_sel`.
  - Reset value is 0.
- Write state machine:
  - States: WRITING, PENDING_SWAP.
  - Reset state is WRITING.
- WRITING:
  - `fb_ready_to_switch_out` = 2'b11.
  - When `ray_valid_in` is high, write `ray_pixel_in` to the back buffer at `ray_address_in`.
  - If `ray_last_pixel_in` is also high, commit that write and go to PENDING_SWAP on the next cycle.
- PENDING_SWAP:
  - `fb_ready_to_switch_out` = 2'b01.
  - Every write is dropped, whether or not `ray_valid_in` is high; no array changes.
  - Swap condition: `hcount_in` == 0 and `vcount_in` == FULL_SCREEN_HEIGHT, i.e. the first blanking line.
  - On the swap condition: toggle `front_sel`, pulse `frame_swap_out`, return to WRITING.
- Address rule: writes with `ray_address_in` >= 57600 are discarded. The last-pixel flag on such a discarded write still advances the state machine.
- Read path:
  - Read address = (`hcount_in` >> 2) + (`vcount_in` >> 2)*320.
  - The multiply is implemented as shift-add: (v<<8) + (v<<6), where v = `vcount_in` >> 2.
  - The read address is 16 bits wide and cannot overflow inside the active region: the maximum is 319 + 179*320 = 57599.
- Output: `pixel_out` is the array data when `active_draw_in` (delayed to match the read latency) is high, otherwise 0.
- Ownership: the front buffer is never written. The back buffer is never read by the display.
- Memory contents are not cleared by reset.

## Timing
- Reset values, applied asynchronously while `rst_n_in` is 0:
  - state = WRITING.
  - `front_sel` = 0.
  - `fb_ready_to_switch_out` = 2'b11.
  - `frame_swap_out` = 0.
  - `pixel_out` = 0.
  - All internal delay registers = 0.
- Reset is released synchronously to the clock: the first active edge after release behaves as WRITING.
- Write latency: data is in the array one cycle after the accepting edge. A write to array address A is visible to the display on the first frame after the next swap.
- Read latency: 2 cycles from `hcount_in`/`vcount_in` to `pixel_out`.
  - Cycle 1: address register plus array read.
  - Cycle 2: output register.
  - `active_draw_in` is delayed by 2 cycles to stay aligned.
- Status timing: `fb_ready_to_switch_out` is registered. It changes 1 cycle after the last-pixel edge and 1 cycle after the swap edge.
- `frame_swap_out` is high for exactly one cycle, the cycle after the swap condition is sampled.
- Simultaneous events:
  - A last pixel accepted on the same cycle as a swap-condition cycle does not swap on that cycle. The swap occurs at the next frame's swap condition.
  - A swap condition seen while in WRITING is ignored; no swap and no pulse.
- Reset mid-frame:
  - Any partially written back buffer is abandoned and state returns to WRITING.
  - `front_sel` returns to 0, so the next frame is written into array 1.

## Test plan
- Reset with `rst_n_in`=0 mid-clock, no clock edge -> `fb_ready_to_switch_out`=3, `pixel_out`=0, `frame_swap_out`=0 immediately.
- Write address 0 = 8'h2A and address 57599 = 8'hDC; last pixel on the second write; then run the display to the swap point and into the next frame -> status 3 then 1 then 3; one swap pulse; `pixel_out`=8'h2A at (h,v)=(0..3, 0..3) and 8'hDC at (1276..1279, 716..719), both 2 cycles late.
- While in PENDING_SWAP, write 8'h97 to address 100 -> after the swap, the display at (h=400, v=0) shows the pre-PENDING value, not 8'h97.
- Last pixel accepted on the same cycle as the swap condition (hcount=0, vcount=720) -> no swap pulse on that cycle; swap occurs exactly one display frame later.
- Write to address 60000 carrying the last-pixel flag -> no array change; state goes to PENDING_SWAP and status=1.
- Assert reset while in PENDING_SWAP with `front_sel`=1 -> state WRITING, status 3, `front_sel`=0; the next frame is written into array 1.
